// File: rtl/wash_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wash_cycle_sequencer
// Purpose  : Timed sequencer for one complete wash/rinse programme. Phases
//            advance on prescaler ticks, the water-level sensor and the door
//            interlock; drives the hot/cold valves, drum motor and door latch.
// Ports    : clkorig     - system clock, rising edge
//            reset       - synchronous active-high reset
//            power       - mains enable, low forces Off (fault is kept)
//            start       - level; begins a programme in Idle or clears fault
//            door        - 1 = door open (pauses fill/agitate phases)
//            level_full  - 1 = drum full
//            tick        - one-cycle timebase enable
//            phase[2:0]  - current phase (Off=0 .. Rinse_spin=7)
//            water[1:0]  - valve drive, MSB hot, LSB cold
//            motor[1:0]  - 00 off, 01 agitate, 10 spin
//            door_lock   - door latch solenoid
//            busy        - programme in progress (phase 2..7)
//            done        - one-cycle pulse when Rinse_spin completes
//            fault       - sticky fill-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module wash_cycle_sequencer #(
  parameter int CNT_W         = 8,
  parameter int AGITATE_TICKS = 20,
  parameter int SPIN_TICKS    = 10,
  parameter int FILL_TIMEOUT  = 30
) (
  input  logic       clkorig,
  input  logic       reset,
  input  logic       power,
  input  logic       start,
  input  logic       door,
  input  logic       level_full,
  input  logic       tick,
  output logic [2:0] phase,
  output logic [1:0] water,
  output logic [1:0] motor,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_OFF           = 3'd0,
    ST_IDLE          = 3'd1,
    ST_WASH_FILL     = 3'd2,
    ST_WASH_AGITATE  = 3'd3,
    ST_WASH_SPIN     = 3'd4,
    ST_RINSE_FILL    = 3'd5,
    ST_RINSE_AGITATE = 3'd6,
    ST_RINSE_SPIN    = 3'd7
  } state_t;

  // Counter value on which the terminal tick of each phase lands.
  localparam logic [CNT_W-1:0] c_agit_last = CNT_W'(AGITATE_TICKS - 1);
  localparam logic [CNT_W-1:0] c_spin_last = CNT_W'(SPIN_TICKS - 1);
  localparam logic [CNT_W-1:0] c_fill_last = CNT_W'(FILL_TIMEOUT - 1);

  state_t           r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_pause, w_pause_nxt;
  logic             r_fault, w_fault_nxt;
  logic             r_done, w_done_nxt;

  always_ff @(posedge clkorig) begin
    if (reset) begin
      r_phase <= ST_OFF;
      r_cnt   <= '0;
      r_pause <= 1'b0;
      r_fault <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pause <= w_pause_nxt;
      r_fault <= w_fault_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_pause_nxt = 1'b0;
    w_fault_nxt = r_fault;
    w_done_nxt  = 1'b0;
    w_cnt_inc   = r_cnt + 1'b1;

    if (!power) begin
      // Programme is abandoned; only the fault flag survives a power loss.
      w_phase_nxt = ST_OFF;
      w_cnt_nxt   = '0;
    end else begin
      case (r_phase)
        ST_OFF: begin
          w_phase_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end

        ST_IDLE: begin
          if (start) begin
            if (r_fault) begin
              w_fault_nxt = 1'b0;
            end else if (!door) begin
              w_phase_nxt = ST_WASH_FILL;
              w_cnt_nxt   = '0;
            end
          end
        end

        ST_WASH_FILL, ST_RINSE_FILL: begin
          // Open door freezes everything, including a coincident tick.
          if (door) begin
            w_pause_nxt = 1'b1;
          end else if (level_full) begin
            // Sensor wins over a coincident timeout.
            w_phase_nxt = (r_phase == ST_WASH_FILL) ? ST_WASH_AGITATE
                                                    : ST_RINSE_AGITATE;
            w_cnt_nxt   = '0;
          end else if (tick) begin
            if (r_cnt == c_fill_last) begin
              w_fault_nxt = 1'b1;
              w_phase_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end

        ST_WASH_AGITATE, ST_RINSE_AGITATE: begin
          if (door) begin
            w_pause_nxt = 1'b1;
          end else if (tick) begin
            if (r_cnt == c_agit_last) begin
              w_phase_nxt = (r_phase == ST_WASH_AGITATE) ? ST_WASH_SPIN
                                                         : ST_RINSE_SPIN;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end

        ST_WASH_SPIN, ST_RINSE_SPIN: begin
          // Door is latched during spin, so it is not looked at here.
          if (tick) begin
            if (r_cnt == c_spin_last) begin
              w_cnt_nxt = '0;
              if (r_phase == ST_WASH_SPIN) begin
                w_phase_nxt = ST_RINSE_FILL;
              end else begin
                w_phase_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end

        default: begin
          w_phase_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Actuators are decoded from registered phase and pause only.
  always_comb begin
    water     = 2'b00;
    motor     = 2'b00;
    door_lock = 1'b0;
    case (r_phase)
      ST_WASH_FILL:     water = r_pause ? 2'b00 : 2'b10;
      ST_RINSE_FILL:    water = r_pause ? 2'b00 : 2'b01;
      ST_WASH_AGITATE,
      ST_RINSE_AGITATE: motor = r_pause ? 2'b00 : 2'b01;
      ST_WASH_SPIN,
      ST_RINSE_SPIN: begin
        motor     = 2'b10;
        door_lock = 1'b1;
      end
      default: ;
    endcase
  end

  assign phase = r_phase;
  assign busy  = (r_phase != ST_OFF) && (r_phase != ST_IDLE);
  assign done  = r_done;
  assign fault = r_fault;

endmodule
`default_nettype wire

// File: doc/wash_cycle_sequencer.md
# wash_cycle_sequencer

- Timed sequencer that drives the washing machine through one complete wash/rinse programme.
- Phase advance is based on:
  - a prescaler tick;
  - a water-level sensor;
  - a door interlock.
- Drives the water valves and the drum motor.
- Sits between the front-panel inputs (power, start, door) and the valve/motor actuators.
- Publishes the current phase in the machine's standard 3-bit state encoding.

## Interface
Parameters:
- CNT_W, 8: width of the phase tick counter.
- AGITATE_TICKS, 20: ticks spent in each agitate phase; legal range 1..2^CNT_W-1.
- SPIN_TICKS, 10: ticks spent in each spin phase; legal range 1..2^CNT_W-1.
- FILL_TIMEOUT, 30: maximum ticks allowed in a fill phase before a fault is raised.

Ports:
- clkorig  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- power  in  1  mains enable; low forces Off.
- start  in  1  level; sampled in Idle to begin a programme; also clears fault.
- door  in  1  1 = door open.
- level_full  in  1  water level sensor, 1 = drum full.
- tick  in  1  one-cycle timebase enable from the prescaler.
- phase  out  3  Off=0, Idle=1, Wash_fill=2, Wash_agitate=3, Wash_spin=4, Rinse_fill=5, Rinse_agitate=6, Rinse_spin=7.
- water  out  2  valve drive; MSB = hot, LSB = cold.
- motor  out  2  00 = off, 01 = agitate, 10 = spin.
- door_lock  out  1  door latch solenoid.
- busy  out  1  programme in progress (phase 2..7).
- done  out  1  one-cycle pulse on completion of Rinse_spin.
- fault  out  1  sticky fill-timeout flag.

## Operation
- reset = 1: all outputs 0; phase = Off; counter = 0. Reset has priority over everything.
- power = 0 (reset low): same as reset, except fault is held. Next cycle with power = 1 moves Off -> Idle.
- Idle:
  - outputs are 0;
  - start = 1, door = 0 and fault = 0 -> Wash_fill, counter cleared;
  - start = 1 with fault = 1: clears fault and stays in Idle.
- Fill phases:
  - Wash_fill: water = 2'b10.
  - Rinse_fill: water = 2'b01.
  - level_full = 1 -> advance to the agitate phase.
  - On each tick, counter increments. If counter == FILL_TIMEOUT-1 on a tick and level_full = 0: set fault, go to Idle.
  - If level_full and the timeout coincide, level_full wins.
- Agitate phases:
  - motor = 01; water is held at the fill value's bit cleared (00).
  - Advance after exactly AGITATE_TICKS ticks.
- Spin phases:
  - motor = 10; door_lock = 1.
  - Advance after exactly SPIN_TICKS ticks.
  - Rinse_spin -> Idle with done = 1 for one cycle.
- Tick counting: counter is cleared on every phase entry. On a tick where counter == N-1, advance; otherwise counter++. Ticks are counted only while not paused.
- Door pause:
  - Applies in fill and agitate phases when door = 1.
  - water and motor are forced to 0; counter and phase are frozen.
  - Resumes on the first cycle with door = 0.
  - In spin phases, door is ignored (latched).
- Outputs are decoded from the registered phase and pause state.
- Phase sequence wraps only through Idle. No illegal encodings are reachable; any illegal encoding -> Idle.

## Timing
- All outputs are registered and update one cycle after the causing input.
- Example: start sampled at edge k -> phase = 2 and water = 10 after edge k.
- An agitate or spin phase of N ticks with tick held high lasts exactly N cycles.
- done is asserted in the same cycle phase becomes Idle.
- door_lock falls in the same cycle phase leaves Rinse_spin.
- Simultaneous tick and door open in a non-spin phase: the pause wins and the tick is dropped.
- power falling mid-programme: phase = Off on the next edge; the programme is abandoned, not resumed.

## Test plan
Parameters for all scenarios: AGITATE_TICKS=4, SPIN_TICKS=3, FILL_TIMEOUT=5.
1. Full programme.
   - Stimulus: tick = 1 constantly; start pulse; level_full raised 2 cycles into each fill.
   - Required phase sequence: 1, 2, 2, 3×4, 4×3, 5, 5, 6×4, 7×3, 1.
   - done pulses once; busy high throughout phases 2..7.
2. Fill timeout.
   - Stimulus: level_full held 0.
   - Required: after 5 ticks in Wash_fill, phase = 1 and fault = 1.
   - start then clears fault without starting a programme.
   - A second start runs the programme.
3. Door pause in Wash_agitate.
   - Stimulus: door = 1 after 2 ticks, held for 6 cycles.
   - Required: motor = 00 and phase = 3 held during the pause.
   - After door = 0: 2 more ticks, then phase = 4.
4. Door during spin.
   - Stimulus: door = 1 in Wash_spin.
   - Required: no pause; door_lock = 1; phase advances after 3 ticks.
5. Power drop in Rinse_agitate.
   - Required: next cycle phase = 0 and all actuators 0.
   - After power returns: phase = 1, and start is required again.
6. Reset mid-spin.
   - Required: all outputs 0 next cycle, including fault and door_lock.
   - Sparse tick (every 4 cycles): Wash_agitate lasts 16 cycles.
